// File: rtl/fpmult_sched_pkg.sv
// rtl/fpmult_sched_pkg.sv - shared types and helpers for the multiplier scheduler
// Contents: scheduler state enum and the requester index width helper.
package fpmult_sched_pkg;

  typedef enum logic [1:0] {
    SCHED_IDLE  = 2'd0,
    SCHED_ISSUE = 2'd1,
    SCHED_WAIT  = 2'd2,
    SCHED_RESP  = 2'd3
  } sched_state_e;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int idx_w(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

endpackage

// File: rtl/fpmult_rr_pick.sv
// rtl/fpmult_rr_pick.sv - combinational round-robin picker
// Ports:
//   req      in   N_REQ   request vector
//   ptr      in   IDX_W   highest-priority index for this pick
//   gnt      out  N_REQ   one-hot grant (zero when no request)
//   gnt_idx  out  IDX_W   index of the granted requester
//   any      out  1       at least one request present
module fpmult_rr_pick
  import fpmult_sched_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int IDX_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  // Scan offsets from farthest to nearest so the requester closest to ptr
  // (scanning upward with wrap) is the last, and therefore winning, write.
  always_comb begin
    int j;
    j       = 0;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N_REQ;
      if (req[j]) begin
        gnt     = '0;
        gnt[j]  = 1'b1;
        gnt_idx = IDX_W'(j);
        any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpmult_rr_scheduler.sv
// rtl/fpmult_rr_scheduler.sv - round-robin sharing of one iterative multiplier
// Optional feature macro: FPMULT_SCHED_PERF_EN (adds the ops_done counter port).
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req_val/req_rdy       per-requester operand handshake (req_rdy one-hot or zero)
//   req_a/req_b           packed operands, requester i at [i*n +: n]
//   resp_val/resp_rdy     per-requester result handshake (resp_val one-hot or zero)
//   resp_c                shared result bus, qualified by resp_val
//   mul_recv_val/rdy      operand handshake to the multiplier, mul_a/mul_b data
//   mul_send_val/rdy      result handshake from the multiplier, mul_c data
//   ops_done              completed-operation count (FPMULT_SCHED_PERF_EN only)
module fpmult_rr_scheduler
  import fpmult_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int n     = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_val,
  output logic [N_REQ-1:0]   req_rdy,
  input  logic [N_REQ*n-1:0] req_a,
  input  logic [N_REQ*n-1:0] req_b,
  output logic [N_REQ-1:0]   resp_val,
  input  logic [N_REQ-1:0]   resp_rdy,
  output logic [n-1:0]       resp_c,
  output logic               mul_recv_val,
  input  logic               mul_recv_rdy,
  output logic [n-1:0]       mul_a,
  output logic [n-1:0]       mul_b,
  input  logic               mul_send_val,
  output logic               mul_send_rdy,
  input  logic [n-1:0]       mul_c
`ifdef FPMULT_SCHED_PERF_EN
  ,
  output logic [31:0]        ops_done
`endif
);

  localparam int IDX_W = idx_w(N_REQ);

  sched_state_e     state_q;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] grant_q;
  logic [n-1:0]     op_a_q;
  logic [n-1:0]     op_b_q;
  logic [n-1:0]     res_q;

  logic [N_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic [n-1:0]     sel_a;
  logic [n-1:0]     sel_b;
  logic [IDX_W-1:0] ptr_d;
  logic             resp_hs;

  fpmult_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req     (req_val),
    .ptr     (ptr_q),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  assign sel_a   = req_a[int'(pick_idx)*n +: n];
  assign sel_b   = req_b[int'(pick_idx)*n +: n];
  assign resp_hs = (state_q == SCHED_RESP) && resp_rdy[grant_q];
  // Next search starts just past the requester that was served.
  assign ptr_d   = (grant_q == IDX_W'(N_REQ - 1)) ? '0 : grant_q + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SCHED_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      res_q   <= '0;
    end else begin
      case (state_q)
        SCHED_IDLE: begin
          if (pick_any) begin
            op_a_q  <= sel_a;
            op_b_q  <= sel_b;
            grant_q <= pick_idx;
            state_q <= SCHED_ISSUE;
          end
        end
        SCHED_ISSUE: begin
          if (mul_recv_rdy) state_q <= SCHED_WAIT;
        end
        SCHED_WAIT: begin
          if (mul_send_val) begin
            res_q   <= mul_c;
            state_q <= SCHED_RESP;
          end
        end
        SCHED_RESP: begin
          if (resp_hs) begin
            ptr_q   <= ptr_d;
            state_q <= SCHED_IDLE;
          end
        end
        default: state_q <= SCHED_IDLE;
      endcase
    end
  end

  // Outputs are forced to zero while reset is held so nothing stale leaks
  // during the reset cycle itself. Nothing below depends on mul_* inputs.
  always_comb begin
    req_rdy  = '0;
    resp_val = '0;
    if (!reset && state_q == SCHED_IDLE) req_rdy = pick_gnt;
    if (!reset && state_q == SCHED_RESP) resp_val[grant_q] = 1'b1;
  end

  assign mul_recv_val = !reset && (state_q == SCHED_ISSUE);
  assign mul_send_rdy = !reset && (state_q == SCHED_WAIT);
  assign mul_a        = reset ? '0 : op_a_q;
  assign mul_b        = reset ? '0 : op_b_q;
  assign resp_c       = reset ? '0 : res_q;

`ifdef FPMULT_SCHED_PERF_EN
  logic [31:0] ops_done_q;

  always_ff @(posedge clk) begin
    if (reset)        ops_done_q <= '0;
    else if (resp_hs) ops_done_q <= ops_done_q + 32'd1;
  end

  assign ops_done = reset ? '0 : ops_done_q;
`endif

endmodule

// File: tb/tb_fpmult_rr_scheduler.sv
// tb/tb_fpmult_rr_scheduler.sv - self-checking bench for fpmult_rr_scheduler
module tb_fpmult_rr_scheduler;

  localparam int N_REQ = 4;
  localparam int N     = 32;
  localparam int LAT   = 3;

  typedef struct {
    int          idx;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
  } vec_t;

  logic               clk = 1'b0;
  logic               reset;
  logic [N_REQ-1:0]   req_val, req_rdy, resp_val, resp_rdy;
  logic [N_REQ*N-1:0] req_a, req_b;
  logic [N-1:0]       resp_c, mul_a, mul_b, mul_c;
  logic               mul_recv_val, mul_recv_rdy, mul_send_val, mul_send_rdy;
`ifdef FPMULT_SCHED_PERF_EN
  logic [31:0]        ops_done;
`endif

  logic [31:0] cur_a [N_REQ];
  logic [31:0] cur_b [N_REQ];
  logic [31:0] cur_c [N_REQ];

  int   n_pass  = 0;
  int   n_total = 0;
  vec_t sb[$];
  int   grant_log[$];

  always #5 clk = ~clk;

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_a[i*N +: N] = cur_a[i];
      req_b[i*N +: N] = cur_b[i];
    end
  end

  fpmult_rr_scheduler #(.N_REQ(N_REQ), .n(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_val      (req_val),
    .req_rdy      (req_rdy),
    .req_a        (req_a),
    .req_b        (req_b),
    .resp_val     (resp_val),
    .resp_rdy     (resp_rdy),
    .resp_c       (resp_c),
    .mul_recv_val (mul_recv_val),
    .mul_recv_rdy (mul_recv_rdy),
    .mul_a        (mul_a),
    .mul_b        (mul_b),
    .mul_send_val (mul_send_val),
    .mul_send_rdy (mul_send_rdy),
    .mul_c        (mul_c)
`ifdef FPMULT_SCHED_PERF_EN
    ,
    .ops_done     (ops_done)
`endif
  );

  // Q16.16 multiplier model with a fixed compute latency.
  function automatic logic [31:0] qmul(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] p;
    p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    return p[47:16];
  endfunction

  logic        m_busy, m_done, m_rdy_en;
  int          m_cnt;
  logic [31:0] m_res;

  assign mul_recv_rdy = m_rdy_en & ~m_busy & ~m_done;
  assign mul_send_val = m_done;
  assign mul_c        = m_done ? m_res : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_cnt  <= 0;
      m_res  <= '0;
    end else if (m_done) begin
      if (mul_send_rdy) m_done <= 1'b0;
    end else if (m_busy) begin
      if (m_cnt == 0) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end else if (mul_recv_val && mul_recv_rdy) begin
      m_busy <= 1'b1;
      m_cnt  <= LAT;
      m_res  <= qmul(mul_a, mul_b);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fail(input string name);
    n_total++;
    $display("FAIL %s: got timeout, expected event", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: pushes on operand acceptance, checks the multiplier
  // operands, pops and compares on every response handshake.
  always @(negedge clk) begin
    int               g;
    vec_t             e;
    logic [N_REQ-1:0] hs;
    g  = 0;
    hs = req_val & req_rdy;
    if (reset) begin
      sb.delete();
    end else begin
      if (|hs) begin
        for (int i = 0; i < N_REQ; i++) if (hs[i]) g = i;
        chk("req_rdy_onehot", 64'($countones(req_rdy)), 64'd1);
        sb.push_back('{g, cur_a[g], cur_b[g], cur_c[g]});
        grant_log.push_back(g);
      end
      if (mul_recv_val && mul_recv_rdy) begin
        if (sb.size() == 0) fail("mul_issue_unexpected");
        else begin
          chk("mul_a", mul_a, sb[0].a);
          chk("mul_b", mul_b, sb[0].b);
        end
      end
      if (|(resp_val & resp_rdy)) begin
        if (sb.size() == 0) fail("resp_unexpected");
        else begin
          e = sb.pop_front();
          chk("resp_owner", resp_val, 64'(4'(1) << e.idx));
          chk("resp_c", resp_c, e.c);
        end
      end
    end
  end

  task automatic wait_sb_empty(input string name);
    int t;
    t = 0;
    do begin @(negedge clk); t++; end while ((sb.size() != 0 || resp_val != 0) && t < 200);
    if (sb.size() != 0) fail(name);
  endtask

  task automatic wait_grants(input int cnt, input string name);
    int t;
    t = 0;
    do begin @(negedge clk); t++; end while (grant_log.size() < cnt && t < 300);
    if (grant_log.size() < cnt) fail(name);
  endtask

  task automatic do_reset();
    tick();
    reset   = 1'b1;
    req_val = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic run_single(input vec_t v);
    int t;
    tick();
    cur_a[v.idx] = v.a;
    cur_b[v.idx] = v.b;
    cur_c[v.idx] = v.c;
    resp_rdy     = '1;
    req_val      = 4'(1) << v.idx;
    t = 0;
    do begin @(negedge clk); t++; end while (!req_rdy[v.idx] && t < 20);
    if (!req_rdy[v.idx]) begin
      fail("single_accept");
      tick();
      req_val = '0;
      return;
    end
    chk("single_rdy_vec", req_rdy, 64'(4'(1) << v.idx));
    tick();
    req_val = '0;
    @(negedge clk);
    chk("issue_latency", mul_recv_val, 1);
    t = 0;
    do begin @(negedge clk); t++; end while (!(mul_send_val && mul_send_rdy) && t < 50);
    if (!(mul_send_val && mul_send_rdy)) begin
      fail("single_result");
      return;
    end
    @(negedge clk);
    chk("resp_latency", resp_val, 64'(4'(1) << v.idx));
    @(negedge clk);
    chk("back_to_idle", resp_val, 0);
  endtask

  vec_t vecs[6];
  int   exp_order[5];

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          t;
    logic        stable;
    logic [3:0]  rv;
    logic [31:0] rc, ma, mb;

    vecs[0] = '{0, 32'h0001_8000, 32'h0002_0000, 32'h0003_0000};
    vecs[1] = '{1, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000};
    vecs[2] = '{2, 32'hFFFF_0000, 32'h0000_8000, 32'hFFFF_8000};
    vecs[3] = '{3, 32'h0002_0000, 32'hFFFE_0000, 32'hFFFC_0000};
    vecs[4] = '{0, 32'h0000_4000, 32'h0000_4000, 32'h0000_1000};
    vecs[5] = '{1, 32'h7FFF_0000, 32'h0000_0000, 32'h0000_0000};
    exp_order = '{0, 1, 2, 3, 0};

    for (int i = 0; i < N_REQ; i++) begin
      cur_a[i] = '0;
      cur_b[i] = '0;
      cur_c[i] = '0;
    end
    reset    = 1'b1;
    req_val  = '1;
    resp_rdy = '1;
    m_rdy_en = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("rdy_in_reset", req_rdy, 0);
    tick();
    reset   = 1'b0;
    req_val = '0;
    @(negedge clk);
    chk("reset_handshakes", {req_rdy, resp_val, mul_recv_val, mul_send_rdy}, 0);
    chk("reset_data", {mul_a, resp_c}, 0);
`ifdef FPMULT_SCHED_PERF_EN
    chk("ops_done_reset", ops_done, 0);
`endif

    // Single-requester table
    for (int i = 0; i < 6; i++) run_single(vecs[i]);

    // All four requesters valid from reset: round-robin order
    do_reset();
    for (int i = 0; i < N_REQ; i++) begin
      cur_a[i] = vecs[i].a;
      cur_b[i] = vecs[i].b;
      cur_c[i] = vecs[i].c;
    end
    grant_log.delete();
    resp_rdy = '1;
    req_val  = '1;
    wait_grants(5, "rr_grants");
    tick();
    req_val = '0;
    wait_sb_empty("rr_drain");
    if (grant_log.size() >= 5)
      for (int k = 0; k < 5; k++) chk("rr_order", 64'(grant_log[k]), 64'(exp_order[k]));

    // Response back-pressure: owner's resp_rdy low 10 cycles, others high
    tick();
    cur_a[1] = 32'h0003_0000; cur_b[1] = 32'h0000_4000; cur_c[1] = 32'h0000_C000;
    cur_a[2] = 32'h0000_8000; cur_b[2] = 32'h0000_8000; cur_c[2] = 32'h0000_4000;
    grant_log.delete();
    resp_rdy = 4'b1101;
    req_val  = 4'b0110;
    t = 0;
    do begin @(negedge clk); t++; end while (resp_val == 0 && t < 100);
    if (resp_val == 0) fail("hold_resp");
    rv = resp_val;
    rc = resp_c;
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (resp_val !== rv || resp_c !== rc || req_rdy !== 4'b0000) stable = 1'b0;
    end
    chk("hold_owner", rv, 64'(4'b0010));
    chk("hold_stable", stable, 1);
    tick();
    resp_rdy = '1;
    wait_grants(2, "hold_next_grant");
    tick();
    req_val = '0;
    wait_sb_empty("hold_drain");
    if (grant_log.size() >= 2) begin
      chk("hold_first", 64'(grant_log[0]), 64'd1);
      chk("hold_next", 64'(grant_log[1]), 64'd2);
    end

    // Operand back-pressure: mul_recv_rdy low 5 cycles in ISSUE
    tick();
    cur_a[3] = 32'hFFFF_8000; cur_b[3] = 32'hFFFF_8000; cur_c[3] = 32'h0000_4000;
    m_rdy_en = 1'b0;
    req_val  = 4'b1000;
    t = 0;
    do begin @(negedge clk); t++; end while (!mul_recv_val && t < 50);
    if (!mul_recv_val) fail("issue_enter");
    tick();
    req_val = '0;
    ma = mul_a;
    mb = mul_b;
    stable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (mul_a !== ma || mul_b !== mb || mul_recv_val !== 1'b1 || mul_send_rdy !== 1'b0) stable = 1'b0;
    end
    chk("issue_stable", stable, 1);
    chk("issue_operand", {ma, mb}, {32'hFFFF_8000, 32'hFFFF_8000});
    tick();
    m_rdy_en = 1'b1;
    @(negedge clk);
    chk("wait_not_early", mul_send_rdy, 0);
    @(negedge clk);
    chk("wait_entered", mul_send_rdy, 1);
    wait_sb_empty("issue_drain");

    // Reset during WAIT
    run_single(vecs[2]);
    tick();
    cur_a[0] = 32'h0000_C000; cur_b[0] = 32'h0000_C000; cur_c[0] = 32'h0000_9000;
    req_val = 4'b0001;
    t = 0;
    do begin @(negedge clk); t++; end while (!mul_send_rdy && t < 50);
    if (!mul_send_rdy) fail("wait_enter");
    tick();
    reset   = 1'b1;
    req_val = 4'b0001;
    @(negedge clk);
    chk("outputs_in_reset", {req_rdy, resp_val, mul_recv_val, mul_send_rdy, mul_a, mul_b, resp_c}, 0);
    tick();
    @(negedge clk);
    chk("outputs_after_reset", {req_rdy, resp_val, mul_recv_val, mul_send_rdy, mul_a, mul_b, resp_c}, 0);
`ifdef FPMULT_SCHED_PERF_EN
    chk("ops_done_after_reset", ops_done, 0);
`endif
    tick();
    reset   = 1'b0;
    grant_log.delete();
    req_val = 4'b1001;
    wait_grants(1, "post_reset_grant");
    tick();
    req_val = '0;
    if (grant_log.size() >= 1) chk("ptr_after_reset", 64'(grant_log[0]), 64'd0);
    wait_sb_empty("post_reset_drain");
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (resp_val !== 4'b0000) stable = 1'b0;
    end
    chk("no_stale_resp", stable, 1);

    for (int i = 0; i < 6; i++) run_single(vecs[i]);
`ifdef FPMULT_SCHED_PERF_EN
    @(negedge clk);
    chk("ops_done_seven", ops_done, 64'd7);
`endif

    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fpmult_rr_scheduler.md
# fpmult_rr_scheduler

Shares one iterative fixed-point multiplier (val/rdy operand port, val/rdy result port, one operation in flight) among `N_REQ` independent requesters. Round-robin arbitration; at most one multiply outstanding. Each result returns only on the response channel of the requester that issued it. Sits between DSP-side clients (filter taps, FFT twiddle stages) and a single `n`-bit multiplier instance; both blocks share `clk`/`reset`.

## Interface
- `N_REQ`, 4, number of requesters (2..16)
- `n`, 32, operand/result width; fixed-point format is the multiplier's concern, this block treats data as opaque bits
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `req_val`  in  N_REQ  request valid, one bit per requester
- `req_rdy`  out  N_REQ  request accepted (one-hot or zero)
- `req_a`  in  N_REQ*n  operand a; requester i at bits [i*n +: n]
- `req_b`  in  N_REQ*n  operand b, same packing
- `resp_val`  out  N_REQ  result valid (one-hot or zero)
- `resp_rdy`  in  N_REQ  requester can take result
- `resp_c`  out  n  result, shared by all requesters; qualified by `resp_val[i]`
- `mul_recv_val`  out  1  operands valid to multiplier
- `mul_recv_rdy`  in  1  multiplier accepts operands
- `mul_a`, `mul_b`  out  n  operands to multiplier
- `mul_send_val`  in  1  multiplier result valid
- `mul_send_rdy`  out  1  scheduler takes result
- `mul_c`  in  n  multiplier result
- `ops_done`  out  32  completed-operation count (only with `FPMULT_SCHED_PERF_EN`)

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset -> IDLE, `ptr`=0, `grant`=0, operand/result registers 0.
- IDLE: winner = first `i` with `req_val[i]`, scanning from `ptr` upward, wrapping. `req_rdy[winner]`=1 combinationally in the same cycle, all other bits 0; latch `req_a/b[winner]` into `op_a/op_b`, latch `grant`=winner; -> ISSUE. No `req_val` -> stay.
- ISSUE: `mul_recv_val`=1, `mul_a/b`=`op_a/op_b` (held stable). On `mul_recv_val & mul_recv_rdy` -> WAIT.
- WAIT: `mul_send_rdy`=1. On `mul_send_val & mul_send_rdy`: `res`<=`mul_c`; -> RESP.
- RESP: `resp_val[grant]`=1, `resp_c`=`res`. On `resp_rdy[grant]`: `ptr`<=(`grant`+1) mod `N_REQ`; -> IDLE.
- `req_rdy` is 0 outside IDLE; `mul_recv_val` 0 outside ISSUE; `mul_send_rdy` 0 outside WAIT; `resp_val` 0 outside RESP. All outputs 0 during/after reset.
- `resp_c` holds `res` in every state (0 after reset).
- Fairness: a requester holding `req_val` waits at most `N_REQ-1` other operations.
- `resp_rdy` bits other than `grant` are ignored. A requester may deassert `req_val` before grant without penalty.
- Reset mid-operation: FSM abandons the operation, no response is produced. The multiplier must be reset in the same cycle via the shared `reset`.

## Timing
- Request accepted in cycle T (IDLE). `mul_recv_val` rises T+1.
- Multiplier compute latency L follows operand acceptance. Result captured the cycle `mul_send_val` is seen in WAIT. `resp_val` rises the next cycle.
- Minimum turnaround: response handshake in cycle R, next request accepted no earlier than R+1 (IDLE entry). Back-to-back overhead is therefore 3 cycles plus L.
- No combinational path from `mul_*` inputs to `req_*`/`resp_*` outputs. `req_rdy` depends combinationally on `req_val`, `ptr` and state only.

## Configuration
- `FPMULT_SCHED_PERF_EN` defined: `ops_done` port exists. It is a 32-bit register, 0 on reset, incremented on each RESP handshake, wrapping at 2^32.
- Undefined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Package `fpmult_sched_pkg`: state enum (`SCHED_IDLE`, `SCHED_ISSUE`, `SCHED_WAIT`, `SCHED_RESP`) and `IDX_W = $clog2(N_REQ)` helper function.
- One sub-module `fpmult_rr_pick`: combinational round-robin picker. Inputs: `req` vector, `ptr`. Outputs: one-hot `gnt`, `gnt_idx`, `any`.

## Test plan
- Single requester 0, Q16.16, a=0x00018000, b=0x00020000 -> `mul_a/b` match, then `resp_val[0]` with `resp_c`=0x00030000 (returned by the multiplier model); other `resp_val` bits stay 0.
- All four requesters valid continuously from reset -> grant order 0,1,2,3,0; each gets its own product (e.g. req2 a=0xFFFF0000, b=0x00008000 -> 0xFFFF8000).
- `resp_rdy[grant]` held low 10 cycles -> `resp_val` and `resp_c` stable; no new `req_rdy` until the response handshake.
- `mul_recv_rdy` low 5 cycles in ISSUE -> `mul_a/b` stable; WAIT entered only on the handshake cycle.
- Reset asserted in WAIT -> next cycle all outputs 0, state IDLE, `ptr`=0; no stale `resp_val` after the multiplier later completes.
- With `FPMULT_SCHED_PERF_EN`: 7 completed operations -> `ops_done`=7; after reset `ops_done`=0.
